// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: push/pop stream and status bundle for sram_fifo_ctrl.
// master = producer/consumer side, slave = the FIFO controller.
interface sram_fifo_ctrl_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 9
) ();
  logic                  push_valid;
  logic [WIDTH-1:0]      push_data;
  logic                  push_ready;
  logic                  pop_valid;
  logic [WIDTH-1:0]      pop_data;
  logic                  pop_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, count, full, empty
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, count, full, empty
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: streaming FIFO on a single-port 512x16 SRAM macro.
// One macro access per cycle, round-robin between write and read when both
// want the port; a 2-entry prefetch buffer (head/skid) hides read latency.
// Optional feature macro: SRAM_FIFO_BYPASS_EN -- when the SRAM and read pipe
// are empty and the buffer has room, pushes go straight into the buffer.
module sram_fifo_ctrl #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  CLK,
  input  logic                  RESET,
  sram_fifo_ctrl_if.slave       fifo,
  output logic                  sram_ceb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [WIDTH-1:0]      sram_d,
  input  logic [WIDTH-1:0]      sram_q,
  output logic [1:0]            sram_rtsel,
  output logic [1:0]            sram_wtsel
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Registered state
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   sram_cnt_r;
  logic                  inflight_r;
  logic [WIDTH-1:0]      head_r;
  logic [WIDTH-1:0]      skid_r;
  logic [1:0]            buf_cnt_r;
  logic                  last_grant_r;   // 0 = write won last contest, 1 = read
  logic [ADDR_WIDTH-1:0] last_a_r;
  logic [WIDTH-1:0]      last_d_r;

  // Combinational control
  logic                  full_s;
  logic                  rd_req_s;
  logic                  wr_req_s;
  logic                  byp_ok_s;
  logic                  byp_s;
  logic                  push_ready_s;
  logic                  contested_s;
  logic                  wr_grant_s;
  logic                  rd_grant_s;
  logic                  pop_s;
  logic                  in_valid_s;
  logic [WIDTH-1:0]      in_data_s;
  logic [WIDTH-1:0]      head_n_s;
  logic [WIDTH-1:0]      skid_n_s;
  logic [1:0]            buf_cnt_n_s;
  logic [ADDR_WIDTH:0]   sram_cnt_n_s;
  logic [ADDR_WIDTH-1:0] sram_a_s;
  logic [WIDTH-1:0]      sram_d_s;

  assign full_s   = (sram_cnt_r == DEPTH_C);
  // A read is worth issuing only if its data will have a buffer slot to land in.
  assign rd_req_s = !RESET && (sram_cnt_r != CNT_ZERO) &&
                    ((buf_cnt_r + {1'b0, inflight_r}) < 2'd2);

`ifdef SRAM_FIFO_BYPASS_EN
  // Bypass only while nothing older is in the SRAM or the read pipe.
  assign byp_ok_s = !RESET && (sram_cnt_r == CNT_ZERO) && !inflight_r &&
                    (buf_cnt_r != 2'd2);
`else
  assign byp_ok_s = 1'b0;
`endif

  // Ready depends only on state: low when a read would win the contest.
  assign push_ready_s = !RESET && !full_s && !(rd_req_s && !last_grant_r);
  assign byp_s        = fifo.push_valid && push_ready_s && byp_ok_s;
  assign wr_req_s     = !RESET && fifo.push_valid && !full_s && !byp_ok_s;
  assign contested_s  = wr_req_s && rd_req_s;
  assign pop_s        = (buf_cnt_r != 2'd0) && fifo.pop_ready;
  assign in_valid_s   = inflight_r || byp_s;
  assign in_data_s    = inflight_r ? sram_q : fifo.push_data;

  // Round-robin arbitration for the single macro port.
  always_comb begin
    wr_grant_s = 1'b0;
    rd_grant_s = 1'b0;
    if (contested_s) begin
      if (last_grant_r) begin
        wr_grant_s = 1'b1;
      end else begin
        rd_grant_s = 1'b1;
      end
    end else begin
      wr_grant_s = wr_req_s;
      rd_grant_s = rd_req_s;
    end
  end

  // Macro command: address/data hold their last value when idle.
  always_comb begin
    sram_a_s = last_a_r;
    sram_d_s = last_d_r;
    if (wr_grant_s) begin
      sram_a_s = wr_ptr_r;
      sram_d_s = fifo.push_data;
    end else if (rd_grant_s) begin
      sram_a_s = rd_ptr_r;
    end else begin
      sram_a_s = last_a_r;
    end
  end

  // SRAM word count follows the granted access.
  always_comb begin
    sram_cnt_n_s = sram_cnt_r;
    case ({wr_grant_s, rd_grant_s})
      2'b10:   sram_cnt_n_s = sram_cnt_r + CNT_ONE;
      2'b01:   sram_cnt_n_s = sram_cnt_r - CNT_ONE;
      default: sram_cnt_n_s = sram_cnt_r;
    endcase
  end

  // Prefetch buffer update: incoming word vs. pop, keeping head oldest.
  always_comb begin
    head_n_s    = head_r;
    skid_n_s    = skid_r;
    buf_cnt_n_s = buf_cnt_r;
    case ({in_valid_s, pop_s})
      2'b10: begin
        if (buf_cnt_r == 2'd0) begin
          head_n_s    = in_data_s;
          buf_cnt_n_s = 2'd1;
        end else begin
          skid_n_s    = in_data_s;
          buf_cnt_n_s = 2'd2;
        end
      end
      2'b01: begin
        head_n_s    = skid_r;
        buf_cnt_n_s = buf_cnt_r - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_r == 2'd1) begin
          head_n_s = in_data_s;
        end else begin
          head_n_s = skid_r;
          skid_n_s = in_data_s;
        end
      end
      default: begin
        buf_cnt_n_s = buf_cnt_r;
      end
    endcase
  end

  // State registers; reset discards any in-flight read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
      sram_cnt_r   <= CNT_ZERO;
      inflight_r   <= 1'b0;
      head_r       <= {WIDTH{1'b0}};
      skid_r       <= {WIDTH{1'b0}};
      buf_cnt_r    <= 2'd0;
      last_grant_r <= 1'b0;
      last_a_r     <= {ADDR_WIDTH{1'b0}};
      last_d_r     <= {WIDTH{1'b0}};
    end else begin
      if (wr_grant_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        last_d_r <= fifo.push_data;
      end
      if (rd_grant_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (wr_grant_s || rd_grant_s) begin
        last_a_r <= sram_a_s;
      end
      if (contested_s) begin
        last_grant_r <= rd_grant_s;
      end
      sram_cnt_r <= sram_cnt_n_s;
      inflight_r <= rd_grant_s;
      head_r     <= head_n_s;
      skid_r     <= skid_n_s;
      buf_cnt_r  <= buf_cnt_n_s;
    end
  end

  assign sram_ceb   = !(wr_grant_s || rd_grant_s);
  assign sram_web   = !wr_grant_s;
  assign sram_a     = sram_a_s;
  assign sram_d     = sram_d_s;
  assign sram_rtsel = 2'b00;
  assign sram_wtsel = 2'b00;

  assign fifo.push_ready = push_ready_s;
  assign fifo.pop_valid  = (buf_cnt_r != 2'd0);
  assign fifo.pop_data   = head_r;
  assign fifo.count      = sram_cnt_r + {{ADDR_WIDTH{1'b0}}, inflight_r} +
                           {{(ADDR_WIDTH-1){1'b0}}, buf_cnt_r};
  assign fifo.full       = full_s;
  assign fifo.empty      = (fifo.count == CNT_ZERO);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed scoreboard bench for sram_fifo_ctrl with a
// behavioural single-port SRAM macro model (Q registered one cycle after read).
module tb_sram_fifo_ctrl;
  localparam int WIDTH = 16;
  localparam int AW    = 9;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          sram_ceb, sram_web;
  logic [AW-1:0] sram_a;
  logic [15:0]   sram_d;
  logic [15:0]   sram_q = 16'h0000;
  logic [1:0]    sram_rtsel, sram_wtsel;
  logic [15:0]   mem [0:511];

  always #5 CLK = ~CLK;

  sram_fifo_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) fifo ();

  sram_fifo_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .fifo(fifo),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q),
    .sram_rtsel(sram_rtsel), .sram_wtsel(sram_wtsel)
  );

  // Macro model
  always @(posedge CLK) begin
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a] <= sram_d;
      else           sram_q      <= mem[sram_a];
    end
  end

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  logic [15:0] exp_q [$];
  logic        held_v = 1'b0;
  logic [15:0] held_d = 16'h0000;
  int          push_n = 0;
  int          pop_n  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample at negedge: scoreboard push/pop and stall stability.
  task automatic sample();
    @(negedge CLK);
    if (held_v && !RESET) begin
      chk("stall_valid", {31'd0, fifo.pop_valid}, 32'd1);
      chk("stall_data", {16'd0, fifo.pop_data}, {16'd0, held_d});
    end
    if (fifo.push_valid && fifo.push_ready) begin
      exp_q.push_back(fifo.push_data);
      push_n++;
    end
    if (fifo.pop_valid && fifo.pop_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_underflow", exp_q.size(), 32'd1);
      end else begin
        chk("pop_data", {16'd0, fifo.pop_data}, {16'd0, exp_q.pop_front()});
        pop_n++;
      end
    end
    held_v = !RESET && fifo.pop_valid && !fifo.pop_ready;
    held_d = fifo.pop_data;
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    fifo.push_valid = 1'b0;
    fifo.pop_ready  = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    fifo.pop_ready = 1'b0;
    chk("drain_done", exp_q.size(), 32'd0);
    sample();
    chk("drain_empty", {31'd0, fifo.empty}, 32'd1);
    chk("drain_count", {22'd0, fifo.count}, 32'd0);
    adv();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    int ctr;
    int max_c;

    // Reset with push_valid held high
    RESET = 1'b1;
    fifo.push_valid = 1'b1;
    fifo.push_data  = 16'h1234;
    fifo.pop_ready  = 1'b0;
    sample();
    chk("rst_ceb0", {31'd0, sram_ceb}, 32'd1);
    chk("rst_ready0", {31'd0, fifo.push_ready}, 32'd0);
    adv();
    sample();
    chk("rst_ceb1", {31'd0, sram_ceb}, 32'd1);
    chk("rst_web", {31'd0, sram_web}, 32'd1);
    chk("rst_count", {22'd0, fifo.count}, 32'd0);
    chk("rst_empty", {31'd0, fifo.empty}, 32'd1);
    chk("rst_full", {31'd0, fifo.full}, 32'd0);
    chk("rst_pop_valid", {31'd0, fifo.pop_valid}, 32'd0);
    chk("rst_pop_data", {16'd0, fifo.pop_data}, 32'd0);
    chk("rst_sram_a", {23'd0, sram_a}, 32'd0);
    chk("rst_sram_d", {16'd0, sram_d}, 32'd0);
    adv();
    RESET = 1'b0;
    fifo.push_valid = 1'b0;
    sample();
    chk("post_rst_ready", {31'd0, fifo.push_ready}, 32'd1);
    adv();

    // Single word latency
    fifo.push_valid = 1'b1;
    fifo.push_data  = 16'hA5A5;
    sample();
`ifdef SRAM_FIFO_BYPASS_EN
    chk("single_byp_ceb", {31'd0, sram_ceb}, 32'd1);
    adv();
    fifo.push_valid = 1'b0;
    fifo.pop_ready  = 1'b1;
    sample();
`else
    chk("single_wr_ceb", {31'd0, sram_ceb}, 32'd0);
    chk("single_wr_web", {31'd0, sram_web}, 32'd0);
    chk("single_wr_a", {23'd0, sram_a}, 32'd0);
    chk("single_wr_d", {16'd0, sram_d}, 32'h0000A5A5);
    adv();
    fifo.push_valid = 1'b0;
    sample();
    chk("single_rd_ceb", {31'd0, sram_ceb}, 32'd0);
    chk("single_rd_web", {31'd0, sram_web}, 32'd1);
    chk("single_rd_a", {23'd0, sram_a}, 32'd0);
    chk("single_count1", {22'd0, fifo.count}, 32'd1);
    adv();
    sample();
    chk("single_not_yet", {31'd0, fifo.pop_valid}, 32'd0);
    adv();
    fifo.pop_ready = 1'b1;
    sample();
`endif
    chk("single_pop_valid", {31'd0, fifo.pop_valid}, 32'd1);
    chk("single_pop_data", {16'd0, fifo.pop_data}, 32'h0000A5A5);
    adv();
    fifo.pop_ready = 1'b0;
    sample();
    chk("single_empty", {31'd0, fifo.empty}, 32'd1);
    adv();

    // Fill to capacity (512 in SRAM + 2 prefetched)
    acc = 0;
    n = 0;
    fifo.push_valid = 1'b1;
    while (acc < 514 && n < 3000) begin
      fifo.push_data = acc[15:0];
      sample();
      if (fifo.push_ready) acc++;
      adv();
      n++;
    end
    fifo.push_valid = 1'b0;
    chk("fill_accepted", acc, 32'd514);
    repeat (3) tick();
    sample();
    chk("fill_full", {31'd0, fifo.full}, 32'd1);
    chk("fill_count", {22'd0, fifo.count}, 32'd514);
    chk("fill_ready", {31'd0, fifo.push_ready}, 32'd0);
    chk("fill_head", {16'd0, fifo.pop_data}, 32'd0);
    adv();
    fifo.push_valid = 1'b1;
    fifo.push_data  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("full_blocks_push", {31'd0, fifo.push_ready}, 32'd0);
      adv();
    end
    drain(3000);
    sample();
    chk("after_fill_full", {31'd0, fifo.full}, 32'd0);
    adv();

    // Contention: push and pop continuously for 1000 cycles
    push_n = 0;
    pop_n  = 0;
    ctr    = 0;
    max_c  = 0;
    fifo.push_valid = 1'b1;
    fifo.pop_ready  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      fifo.push_data = ctr[15:0];
      sample();
      if (fifo.push_ready) ctr++;
      if (int'(fifo.count) > max_c) max_c = int'(fifo.count);
      adv();
    end
    chk("cont_push_rate", {31'd0, push_n >= 480}, 32'd1);
    chk("cont_pop_rate", {31'd0, pop_n >= 480}, 32'd1);
    chk("cont_count_bound", {31'd0, max_c <= 514}, 32'd1);
    drain(2000);

    // Backpressure with random pop_ready across pointer wrap
    ctr = 0;
    n = 0;
    fifo.push_valid = 1'b1;
    while (ctr < 1024 && n < 8000) begin
      fifo.push_data = ctr[15:0];
      fifo.pop_ready = ($urandom_range(0, 1) == 1);
      sample();
      if (fifo.push_ready) ctr++;
      adv();
      n++;
    end
    chk("bp_all_pushed", ctr, 32'd1024);
    drain(3000);

    // Reset one cycle after a read grant
    fifo.push_valid = 1'b1;
    fifo.push_data  = 16'h5A5A;
    fifo.pop_ready  = 1'b0;
    tick();
    fifo.push_valid = 1'b0;
    sample();
`ifndef SRAM_FIFO_BYPASS_EN
    chk("midrst_rd_grant", {31'd0, sram_web}, 32'd1);
    chk("midrst_rd_ceb", {31'd0, sram_ceb}, 32'd0);
`endif
    adv();
    RESET = 1'b1;
    sample();
    chk("midrst_ready", {31'd0, fifo.push_ready}, 32'd0);
    adv();
    exp_q.delete();
    held_v = 1'b0;
    RESET = 1'b0;
    sample();
    chk("midrst_pop_valid", {31'd0, fifo.pop_valid}, 32'd0);
    chk("midrst_pop_data", {16'd0, fifo.pop_data}, 32'd0);
    chk("midrst_count", {22'd0, fifo.count}, 32'd0);
    chk("midrst_empty", {31'd0, fifo.empty}, 32'd1);
    chk("midrst_ceb", {31'd0, sram_ceb}, 32'd1);
    chk("midrst_sram_a", {23'd0, sram_a}, 32'd0);
    chk("midrst_sram_d", {16'd0, sram_d}, 32'd0);
    adv();
    repeat (3) tick();
    sample();
    chk("midrst_no_ghost", {31'd0, fifo.pop_valid}, 32'd0);
    adv();
    fifo.push_valid = 1'b1;
    fifo.push_data  = 16'hC3C3;
    tick();
    drain(20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
